// File: rtl/fc_layer_9_pkg.sv
// fc_layer_9_pkg
// Shared definitions for the 9-class fully connected layer:
//   - NUM_CLASSES and the default feature count / widths
//   - FSM state encoding used by the layer controller
//   - clog2_min1 helper for index widths that must stay at least one bit wide
package fc_layer_9_pkg;

  localparam int NUM_CLASSES = 9;
  localparam int DEF_N_IN    = 64;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIAS = 3'd1,
    ST_WAIT = 3'd2,
    ST_MAC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Index width for a range of v values; never collapses to a zero-width vector.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_9_if.sv
// fc_layer_9_if
// Feature stream, control and score bus of the fully connected layer.
//   start        : request one inference (master -> slave)
//   in_data      : signed feature value (master -> slave)
//   in_valid     : in_data is valid (master -> slave)
//   in_ready     : layer accepts a feature this cycle (slave -> master)
//   data_out0..8 : signed class scores for the argmax stage (slave -> master)
//   done         : scores are final and stable (slave -> master)
//   done_pulse   : one-cycle pulse on the first cycle done is high (slave -> master)
interface fc_layer_9_if
  import fc_layer_9_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
);

  logic                     start;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  data_out0;
  logic signed [ACC_W-1:0]  data_out1;
  logic signed [ACC_W-1:0]  data_out2;
  logic signed [ACC_W-1:0]  data_out3;
  logic signed [ACC_W-1:0]  data_out4;
  logic signed [ACC_W-1:0]  data_out5;
  logic signed [ACC_W-1:0]  data_out6;
  logic signed [ACC_W-1:0]  data_out7;
  logic signed [ACC_W-1:0]  data_out8;
  logic                     done;
  logic                     done_pulse;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, data_out0, data_out1, data_out2, data_out3, data_out4,
           data_out5, data_out6, data_out7, data_out8, done, done_pulse
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, data_out0, data_out1, data_out2, data_out3, data_out4,
           data_out5, data_out6, data_out7, data_out8, done, done_pulse
  );

endinterface

// File: rtl/fc_weight_rom.sv
// fc_weight_rom
// Weight and bias store of the layer with a purely combinational read.
// Contents come from the W_IMAGE / B_IMAGE parameter images, which hold the
// memory-file contents packed element 0 in the least significant bits.
//   w_addr : weight address, feat_idx*NUM_CLASSES + cls
//   w_data : signed weight at w_addr
//   bias   : all NUM_CLASSES signed biases, bias[k] at address k
module fc_weight_rom
  import fc_layer_9_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = clog2_min1(N_IN * NUM_CLASSES),
  parameter logic [N_IN*NUM_CLASSES*DATA_W-1:0] W_IMAGE = '0,
  parameter logic [NUM_CLASSES*ACC_W-1:0]       B_IMAGE = '0
) (
  input  logic        [ADDR_W-1:0] w_addr,
  output logic signed [DATA_W-1:0] w_data,
  output logic signed [ACC_W-1:0]  bias [NUM_CLASSES]
);

  localparam int DEPTH = N_IN * NUM_CLASSES;

  // Table is padded to the full address space so any address decodes;
  // unused entries read as zero.
  logic [DATA_W-1:0] wmem [2**ADDR_W];

  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_wmem
    if (i < DEPTH) begin : g_used
      assign wmem[i] = W_IMAGE[i*DATA_W +: DATA_W];
    end else begin : g_pad
      assign wmem[i] = '0;
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_bias
    assign bias[k] = B_IMAGE[k*ACC_W +: ACC_W];
  end

  assign w_data = wmem[w_addr];

endmodule

// File: rtl/fc_layer_9.sv
// fc_layer_9
// Fully connected layer producing 9 class scores from N_IN streamed features.
// Each accepted feature is multiplied against the 9 class weights, one class per
// cycle, through a single shared multiplier into a 9-entry accumulator array.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high reset
//   bus   : fc_layer_9_if slave (start, feature stream, scores, done flags)
module fc_layer_9
  import fc_layer_9_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter logic [N_IN*NUM_CLASSES*DATA_W-1:0] W_IMAGE = '0,
  parameter logic [NUM_CLASSES*ACC_W-1:0]       B_IMAGE = '0
) (
  input  logic         clk,
  input  logic         reset,
  fc_layer_9_if.slave  bus
);

  localparam int FIDX_W = clog2_min1(N_IN);
  localparam int CLS_W  = clog2_min1(NUM_CLASSES);
  localparam int ADDR_W = clog2_min1(N_IN * NUM_CLASSES);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [FIDX_W-1:0] LAST_FEAT = FIDX_W'(N_IN - 1);
  localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q [NUM_CLASSES];
  logic signed [ACC_W-1:0]  acc_d [NUM_CLASSES];
  logic signed [DATA_W-1:0] feat_q, feat_d;
  logic [FIDX_W-1:0]        feat_idx_q, feat_idx_d;
  logic [CLS_W-1:0]         cls_q, cls_d;
  logic                     done_q, done_d;
  logic                     done_pulse_q, done_pulse_d;

  logic [ADDR_W-1:0]        w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic signed [ACC_W-1:0]  bias [NUM_CLASSES];
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  mac_sum;

  fc_weight_rom #(
    .N_IN    (N_IN),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .ADDR_W  (ADDR_W),
    .W_IMAGE (W_IMAGE),
    .B_IMAGE (B_IMAGE)
  ) u_rom (
    .w_addr (w_addr),
    .w_data (w_data),
    .bias   (bias)
  );

  assign w_addr = ADDR_W'(feat_idx_q) * ADDR_W'(NUM_CLASSES) + ADDR_W'(cls_q);

  // The one multiplier: operands are widened before multiplying so the product
  // is exact, then sign-extended; the adder wraps at ACC_W.
  assign product = PROD_W'(feat_q) * PROD_W'(w_data);
  assign mac_sum = acc_q[cls_q] + ACC_W'(product);

  // Next-state and datapath updates for the controller.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    feat_d     = feat_q;
    feat_idx_d = feat_idx_q;
    cls_d      = cls_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_BIAS;
        end
      end
      ST_BIAS: begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
          acc_d[k] = bias[k];
        end
        feat_idx_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.in_valid) begin
          feat_d  = bus.in_data;
          cls_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d[cls_q] = mac_sum;
        if (cls_q == LAST_CLS) begin
          if (feat_idx_q == LAST_FEAT) begin
            state_d = ST_DONE;
          end else begin
            feat_idx_d = feat_idx_q + FIDX_W'(1);
            state_d    = ST_WAIT;
          end
        end else begin
          cls_d = cls_q + CLS_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // done is registered: it rises on the second DONE cycle, once the final
    // accumulator write has settled, and drops on the edge that takes start.
    done_d       = (state_q == ST_DONE) && (state_d == ST_DONE);
    done_pulse_d = done_d && !done_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '{default: '0};
      feat_q       <= '0;
      feat_idx_q   <= '0;
      cls_q        <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      feat_q       <= feat_d;
      feat_idx_q   <= feat_idx_d;
      cls_q        <= cls_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_WAIT);
  assign bus.done       = done_q;
  assign bus.done_pulse = done_pulse_q;
  assign bus.data_out0  = acc_q[0];
  assign bus.data_out1  = acc_q[1];
  assign bus.data_out2  = acc_q[2];
  assign bus.data_out3  = acc_q[3];
  assign bus.data_out4  = acc_q[4];
  assign bus.data_out5  = acc_q[5];
  assign bus.data_out6  = acc_q[6];
  assign bus.data_out7  = acc_q[7];
  assign bus.data_out8  = acc_q[8];

endmodule

// File: tb/tb_fc_layer_9.sv
// tb_fc_layer_9
// Self-checking bench for fc_layer_9. Three layer instances share clk/reset:
//   dut 0 : N_IN=4, all weights 1, biases 0
//   dut 1 : N_IN=4, W[f][k]=k-4, bias[k]=k
//   dut 2 : N_IN=64, all weights -128, bias[k]=1000*k
// Expected scores are pushed to a scoreboard queue when an inference starts and
// popped when the layer raises done.
module tb_fc_layer_9;

  localparam int N4  = 4;
  localparam int N64 = 64;

  typedef struct packed {
    logic [8:0][31:0] v;
  } exp_t;

  typedef struct packed {
    int               sel;
    int               gap;
    bit               mid;
    logic [3:0][7:0]  f;
    logic [8:0][31:0] e;
  } vec_t;

  function automatic logic [N4*9*8-1:0] w_ramp();
    logic [N4*9*8-1:0] r;
    r = '0;
    for (int f = 0; f < N4; f++)
      for (int k = 0; k < 9; k++)
        r[(f*9+k)*8 +: 8] = 8'(k - 4);
    return r;
  endfunction

  function automatic logic [9*32-1:0] b_scaled(input int scale);
    logic [9*32-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*32 +: 32] = 32'(scale * k);
    return r;
  endfunction

  localparam logic [N4*9*8-1:0]  W_ONES = {(N4*9){8'h01}};
  localparam logic [N4*9*8-1:0]  W_RAMP = w_ramp();
  localparam logic [N64*9*8-1:0] W_NEG  = {(N64*9){8'h80}};
  localparam logic [9*32-1:0]    B_ZERO = '0;
  localparam logic [9*32-1:0]    B_RAMP = b_scaled(1);
  localparam logic [9*32-1:0]    B_THOU = b_scaled(1000);

  logic clk;
  logic reset;
  logic              start_v   [3];
  logic              drv_valid [3];
  logic signed [7:0] drv_data  [3];
  logic              rdy [3];
  logic              dn  [3];
  logic              dp  [3];
  logic signed [31:0] dout [3][9];
  int                acc_cnt [3];

  logic signed [7:0] feat_buf [64];
  exp_t sb_q [$];
  int total;
  int bad;

  fc_layer_9_if #(.DATA_W(8), .ACC_W(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].start    = start_v[g];
    assign bus[g].in_valid = drv_valid[g];
    assign bus[g].in_data  = drv_data[g];
    assign rdy[g]     = bus[g].in_ready;
    assign dn[g]      = bus[g].done;
    assign dp[g]      = bus[g].done_pulse;
    assign dout[g][0] = bus[g].data_out0;
    assign dout[g][1] = bus[g].data_out1;
    assign dout[g][2] = bus[g].data_out2;
    assign dout[g][3] = bus[g].data_out3;
    assign dout[g][4] = bus[g].data_out4;
    assign dout[g][5] = bus[g].data_out5;
    assign dout[g][6] = bus[g].data_out6;
    assign dout[g][7] = bus[g].data_out7;
    assign dout[g][8] = bus[g].data_out8;
  end

  fc_layer_9 #(.N_IN(N4), .DATA_W(8), .ACC_W(32), .W_IMAGE(W_ONES), .B_IMAGE(B_ZERO))
    dut0 (.clk(clk), .reset(reset), .bus(bus[0]));
  fc_layer_9 #(.N_IN(N4), .DATA_W(8), .ACC_W(32), .W_IMAGE(W_RAMP), .B_IMAGE(B_RAMP))
    dut1 (.clk(clk), .reset(reset), .bus(bus[1]));
  fc_layer_9 #(.N_IN(N64), .DATA_W(8), .ACC_W(32), .W_IMAGE(W_NEG), .B_IMAGE(B_THOU))
    dut2 (.clk(clk), .reset(reset), .bus(bus[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every feature handshake per instance to catch lost or duplicated features.
  initial for (int g = 0; g < 3; g++) acc_cnt[g] = 0;
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++)
      if (drv_valid[g] && rdy[g]) acc_cnt[g] <= acc_cnt[g] + 1;
  end

  task automatic check_output(input string name, input logic signed [31:0] act,
                              input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for the layer", name);
  endtask

  // Present n features from feat_buf, each preceded by gap idle cycles.
  task automatic feed(input int sel, input int n, input int gap);
    int waited;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) begin
        drv_valid[sel] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      drv_valid[sel] = 1'b1;
      drv_data[sel]  = feat_buf[i];
      waited = 0;
      while (!rdy[sel] && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) begin
        flag_timeout($sformatf("feed[%0d] feature %0d", sel, i));
        drv_valid[sel] = 1'b0;
        return;
      end
      @(negedge clk);
      check_output($sformatf("rdy_low_in_mac[%0d]", sel), rdy[sel], 0);
    end
    drv_valid[sel] = 1'b0;
  endtask

  // One full inference on instance sel; exp_lat=0 skips the latency check.
  task automatic apply_stimulus(input int sel, input int n, input int gap,
                                input bit mid_start, input int exp_lat, input exp_t exp_in);
    int   edges;
    int   base;
    exp_t e;
    sb_q.push_back(exp_in);
    base = acc_cnt[sel];
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    check_output($sformatf("done_cleared[%0d]", sel), dn[sel], 0);
    edges = 0;
    fork
      feed(sel, n, gap);
      begin
        while (!dn[sel] && edges < 5000) begin
          @(negedge clk);
          edges++;
        end
      end
      begin
        if (mid_start) begin
          repeat (15) @(negedge clk);
          start_v[sel] = 1'b1;
          @(negedge clk);
          start_v[sel] = 1'b0;
        end
      end
    join
    e = sb_q.pop_front();
    if (edges >= 5000) begin
      flag_timeout($sformatf("done[%0d]", sel));
      return;
    end
    if (exp_lat > 0) check_output($sformatf("latency[%0d]", sel), edges, exp_lat);
    check_output($sformatf("pulse_first[%0d]", sel), dp[sel], 1);
    check_output($sformatf("accepted[%0d]", sel), acc_cnt[sel] - base, n);
    for (int k = 0; k < 9; k++)
      check_output($sformatf("data_out%0d[%0d]", k, sel), dout[sel][k], e.v[k]);
    @(negedge clk);
    check_output($sformatf("pulse_single[%0d]", sel), dp[sel], 0);
    check_output($sformatf("done_level[%0d]", sel), dn[sel], 1);
    check_output($sformatf("data_out0_held[%0d]", sel), dout[sel][0], e.v[0]);
  endtask

  initial begin
    vec_t vecs [7];
    exp_t e;
    int   sum;
    int   base;
    int   waited;
    bit   seen_done;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start_v[g]   = 1'b0;
      drv_valid[g] = 1'b0;
      drv_data[g]  = '0;
    end

    vecs[0] = '{sel: 0, gap: 0, mid: 1'b0, f: {8'sd4, 8'sd3, 8'sd2, 8'sd1}, e: {9{32'sd10}}};
    vecs[1] = '{sel: 1, gap: 0, mid: 1'b0, f: {4{-8'sd3}},
                e: {-32'sd40, -32'sd29, -32'sd18, -32'sd7, 32'sd4, 32'sd15, 32'sd26, 32'sd37, 32'sd48}};
    vecs[2] = '{sel: 0, gap: 5, mid: 1'b0, f: {8'sd4, 8'sd3, 8'sd2, 8'sd1}, e: {9{32'sd10}}};
    vecs[3] = '{sel: 0, gap: 0, mid: 1'b1, f: {8'sd4, 8'sd3, 8'sd2, 8'sd1}, e: {9{32'sd10}}};
    vecs[4] = '{sel: 0, gap: 0, mid: 1'b0, f: {8'sd4, 8'sd3, 8'sd2, 8'sd1}, e: {9{32'sd10}}};
    vecs[5] = '{sel: 1, gap: 0, mid: 1'b0, f: {-8'sd1, 8'sd9, -8'sd7, 8'sd5},
                e: {32'sd32, 32'sd25, 32'sd18, 32'sd11, 32'sd4, -32'sd3, -32'sd10, -32'sd17, -32'sd24}};
    vecs[6] = '{sel: 0, gap: 2, mid: 1'b0, f: {8'h7F, 8'h80, 8'h7F, 8'h80}, e: {9{-32'sd2}}};

    #2;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 9; k++)
        check_output($sformatf("reset_out%0d[%0d]", k, g), dout[g][k], 0);
      check_output($sformatf("reset_ready[%0d]", g), rdy[g], 0);
      check_output($sformatf("reset_done[%0d]", g), dn[g], 0);
      check_output($sformatf("reset_pulse[%0d]", g), dp[g], 0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d on dut%0d gap=%0d", i, vecs[i].sel, vecs[i].gap);
      for (int j = 0; j < N4; j++) feat_buf[j] = vecs[i].f[j];
      for (int k = 0; k < 9; k++) e.v[k] = vecs[i].e[k];
      apply_stimulus(vecs[i].sel, N4, vecs[i].gap, vecs[i].mid,
                     (vecs[i].gap == 0) ? 2 + 10 * N4 : 0, e);
    end

    // 64 extreme features against weight -128, checked by a reference sum.
    $display("[TB] 64-feature extreme run on dut2");
    sum = 0;
    for (int i = 0; i < N64; i++) begin
      if (i == 0 || (i != 1 && $urandom_range(0, 1) == 1)) feat_buf[i] = 8'sd127;
      else feat_buf[i] = 8'h80;
      sum += int'(feat_buf[i]);
    end
    for (int k = 0; k < 9; k++) e.v[k] = 32'(1000 * k + (-128) * sum);
    apply_stimulus(2, N64, 0, 1'b0, 2 + 10 * N64, e);

    // Reset in the middle of the third feature's MAC sequence.
    $display("[TB] reset during inference on dut0");
    for (int j = 0; j < N4; j++) feat_buf[j] = 8'(j + 1);
    base = acc_cnt[0];
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    drv_valid[0] = 1'b1;
    drv_data[0]  = 8'sd1;
    waited = 0;
    while (acc_cnt[0] - base < 3 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) flag_timeout("third_feature");
    repeat (3) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < 9; k++)
      check_output($sformatf("midreset_out%0d", k), dout[0][k], 0);
    check_output("midreset_ready", rdy[0], 0);
    check_output("midreset_done", dn[0], 0);
    check_output("midreset_pulse", dp[0], 0);
    drv_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (dn[0] || dp[0]) seen_done = 1'b1;
    end
    check_output("no_done_after_reset", seen_done, 0);

    for (int k = 0; k < 9; k++) e.v[k] = 32'sd10;
    apply_stimulus(0, N4, 0, 1'b0, 2 + 10 * N4, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
